// File: rtl/regfile_wb_ctrl_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_ctrl_if
// Bundle of the signals between the register-file writeback controller and
// its neighbours: ALU writeback, load return handshake, load issue, decode
// hazard check, scoreboard/FIFO status and the register file write port.
//   slave  modport : the controller side (regfile_wb_ctrl)
//   master modport : the pipeline / register-file side driving requests
// ----------------------------------------------------------------------------
interface regfile_wb_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int LD_FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(LD_FIFO_DEPTH) + 1;

    // ALU writeback (no backpressure)
    logic                     alu_wb_valid;
    logic [ADDRESS_WIDTH-1:0] alu_wb_rd;
    logic [DATA_WIDTH-1:0]    alu_wb_data;
    // Load return handshake
    logic                     ld_wb_valid;
    logic                     ld_wb_ready;
    logic [ADDRESS_WIDTH-1:0] ld_wb_rd;
    logic [DATA_WIDTH-1:0]    ld_wb_data;
    // Load issue (scoreboard set)
    logic                     issue_ld_valid;
    logic [ADDRESS_WIDTH-1:0] issue_ld_rd;
    // Decode hazard check
    logic [ADDRESS_WIDTH-1:0] chk_addr1;
    logic [ADDRESS_WIDTH-1:0] chk_addr2;
    logic                     chk_busy;
    // Status
    logic [NUM_REGS-1:0]      sb_busy;
    logic [CNT_W-1:0]         fifo_count;
    // Register file write port
    logic                     rg_wrt_en;
    logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
    logic [DATA_WIDTH-1:0]    rg_wrt_data;

    modport slave (
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  ld_wb_valid, ld_wb_rd, ld_wb_data,
        output ld_wb_ready,
        input  issue_ld_valid, issue_ld_rd,
        input  chk_addr1, chk_addr2,
        output chk_busy, sb_busy, fifo_count,
        output rg_wrt_en, rg_wrt_dest, rg_wrt_data
    );

    modport master (
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output ld_wb_valid, ld_wb_rd, ld_wb_data,
        input  ld_wb_ready,
        output issue_ld_valid, issue_ld_rd,
        output chk_addr1, chk_addr2,
        input  chk_busy, sb_busy, fifo_count,
        input  rg_wrt_en, rg_wrt_dest, rg_wrt_data
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_wb_ctrl
// Owns the single write port of the core register file. Merges single-cycle
// ALU writebacks with load returns (buffered in a small skid FIFO), ALU
// first. Keeps a busy-register scoreboard of outstanding loads for decode
// RAW-hazard stalls.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - regfile_wb_ctrl_if.slave: ALU/load writeback inputs, load
//          handshake, load issue, hazard check, status and write port
// ----------------------------------------------------------------------------
module regfile_wb_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int LD_FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(LD_FIFO_DEPTH);
    localparam int CNT_W = $clog2(LD_FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LD_FIFO_DEPTH);
    // Register 0 is hardwired; its scoreboard bit is always masked off.
    localparam logic [NUM_REGS-1:0] SB_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDRESS_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Load-return skid FIFO
    logic [ADDRESS_WIDTH-1:0] r_fifo_rd   [LD_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    r_fifo_data [LD_FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_rptr;
    logic [CNT_W-1:0]         r_count;

    logic [NUM_REGS-1:0]      r_sb;

    // Registered write port
    logic                     r_vld_p1;
    logic [ADDRESS_WIDTH-1:0] r_dest_p1;
    logic [DATA_WIDTH-1:0]    r_data_p1;

    logic                     w_ready;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_nonempty;
    logic [ADDRESS_WIDTH-1:0] w_head_rd;
    logic [DATA_WIDTH-1:0]    w_head_data;
    logic                     w_vld_p0;
    logic [ADDRESS_WIDTH-1:0] w_dest_p0;
    logic [DATA_WIDTH-1:0]    w_data_p0;
    logic [NUM_REGS-1:0]      w_sb_set;
    logic [NUM_REGS-1:0]      w_sb_clr;

    // Ready comes only from registered occupancy, so a pop in a full cycle
    // re-opens the FIFO one cycle later.
    assign w_ready     = !rst && (r_count < DEPTH_C);
    assign w_push      = bus.ld_wb_valid && w_ready;
    assign w_nonempty  = (r_count != '0);
    assign w_pop       = !bus.alu_wb_valid && w_nonempty;
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= bus.ld_wb_rd;
            r_fifo_data[r_wptr] <= bus.ld_wb_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // ---- p0: arbitration, ALU over FIFO head; rd==0 consumes but never writes
    always_comb begin
        w_vld_p0  = 1'b0;
        w_dest_p0 = '0;
        w_data_p0 = '0;
        if (bus.alu_wb_valid) begin
            w_vld_p0  = (bus.alu_wb_rd != '0);
            w_dest_p0 = bus.alu_wb_rd;
            w_data_p0 = bus.alu_wb_data;
        end else if (w_nonempty) begin
            w_vld_p0  = (w_head_rd != '0);
            w_dest_p0 = w_head_rd;
            w_data_p0 = w_head_data;
        end
    end

    // ---- p1: registered write port to the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_dest_p1 <= '0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1  <= w_vld_p0;
            r_dest_p1 <= w_dest_p0;
            r_data_p1 <= w_data_p0;
        end
    end

    // Scoreboard: the clear lands on the same edge that raises the write,
    // and a simultaneous set of the same index wins.
    always_comb begin
        w_sb_set = '0;
        w_sb_clr = '0;
        if (bus.issue_ld_valid && (bus.issue_ld_rd != '0)) w_sb_set = onehot(bus.issue_ld_rd);
        if (w_pop) w_sb_clr = onehot(w_head_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) r_sb <= '0;
        else     r_sb <= ((r_sb & ~w_sb_clr) | w_sb_set) & SB_MASK;
    end

    assign bus.ld_wb_ready = w_ready;
    assign bus.fifo_count  = r_count;
    assign bus.sb_busy     = r_sb;
    assign bus.chk_busy    = (r_sb[bus.chk_addr1] && (bus.chk_addr1 != '0)) ||
                             (r_sb[bus.chk_addr2] && (bus.chk_addr2 != '0));
    assign bus.rg_wrt_en   = r_vld_p1;
    assign bus.rg_wrt_dest = r_dest_p1;
    assign bus.rg_wrt_data = r_data_p1;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_ctrl
// Directed bench for regfile_wb_ctrl: reset, ALU writeback, load path with
// scoreboard, ALU/load collision with FIFO full, x0 suppression, scoreboard
// set/clear race and reset mid-operation.
// ----------------------------------------------------------------------------
module tb_regfile_wb_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int FD = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    regfile_wb_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .LD_FIFO_DEPTH(FD)) bus ();

    regfile_wb_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .LD_FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy must never exceed the FIFO depth.
    always @(negedge clk) begin
        if (!rst) begin
            assert (bus.fifo_count <= FD) else begin
                n_fail++;
                $error("FAIL fifo_bound: got %0d expected <= %0d", bus.fifo_count, FD);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_wb_valid   = 1'b0;
        bus.alu_wb_rd      = '0;
        bus.alu_wb_data    = '0;
        bus.ld_wb_valid    = 1'b0;
        bus.ld_wb_rd       = '0;
        bus.ld_wb_data     = '0;
        bus.issue_ld_valid = 1'b0;
        bus.issue_ld_rd    = '0;
    endtask

    task automatic alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = rd;
        bus.alu_wb_data  = d;
    endtask

    task automatic ld(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        bus.ld_wb_valid = 1'b1;
        bus.ld_wb_rd    = rd;
        bus.ld_wb_data  = d;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        bus.issue_ld_valid = 1'b1;
        bus.issue_ld_rd    = rd;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [AW-1:0] dest, input logic [DW-1:0] d);
        chk({tag, "_en"},   bus.rg_wrt_en,   en);
        chk({tag, "_dest"}, bus.rg_wrt_dest, dest);
        chk({tag, "_data"}, bus.rg_wrt_data, d);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        idle();
        bus.chk_addr1 = '0;
        bus.chk_addr2 = '0;

        // Reset state
        tick();
        tick();
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_sb", bus.sb_busy, 0);
        chk_wr("rst_wr", 1'b0, 0, 0);
        chk("rst_ready", bus.ld_wb_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.ld_wb_ready, 1);

        // ALU-only
        alu(5, 32'hDEADBEEF);
        tick();
        idle();
        chk_wr("alu_wr", 1'b1, 5, 32'hDEADBEEF);
        tick();
        chk_wr("alu_idle", 1'b0, 0, 0);

        // Load path
        issue(7);
        tick();
        idle();
        chk("ld_sb_set", bus.sb_busy, 32'h80);
        bus.chk_addr1 = 7;
        #1;
        chk("ld_chk1", bus.chk_busy, 1);
        bus.chk_addr1 = 0;
        bus.chk_addr2 = 7;
        #1;
        chk("ld_chk2", bus.chk_busy, 1);
        bus.chk_addr2 = 0;
        bus.chk_addr1 = 6;
        #1;
        chk("ld_chk_other", bus.chk_busy, 0);
        bus.chk_addr1 = 7;
        ld(7, 32'h1234);
        tick();
        idle();
        chk("ld_acc_count", bus.fifo_count, 1);
        chk("ld_acc_en", bus.rg_wrt_en, 0);
        chk("ld_acc_sb", bus.sb_busy, 32'h80);
        tick();
        chk_wr("ld_wr", 1'b1, 7, 32'h1234);
        chk("ld_sb_clr", bus.sb_busy, 0);
        chk("ld_chk_clr", bus.chk_busy, 0);
        chk("ld_count0", bus.fifo_count, 0);
        bus.chk_addr1 = 0;

        // Collision: ALU stream with loads filling the FIFO
        issue(8);
        tick();
        issue(9);
        tick();
        idle();
        chk("col_sb", bus.sb_busy, 32'h300);
        alu(3, 32'h30);
        ld(8, 32'hA);
        tick();
        chk_wr("col_alu0", 1'b1, 3, 32'h30);
        chk("col_count1", bus.fifo_count, 1);
        alu(3, 32'h31);
        ld(9, 32'hB);
        tick();
        chk_wr("col_alu1", 1'b1, 3, 32'h31);
        chk("col_count2", bus.fifo_count, 2);
        chk("col_full_ready", bus.ld_wb_ready, 0);
        alu(3, 32'h32);
        ld(10, 32'hC);
        tick();
        chk_wr("col_alu2", 1'b1, 3, 32'h32);
        chk("col_stall_count", bus.fifo_count, 2);
        chk("col_stall_ready", bus.ld_wb_ready, 0);
        bus.alu_wb_valid = 1'b0;
        tick();
        chk_wr("col_ld8", 1'b1, 8, 32'hA);
        chk("col_pop_count", bus.fifo_count, 1);
        chk("col_ready_back", bus.ld_wb_ready, 1);
        chk("col_sb8", bus.sb_busy, 32'h200);
        tick();
        idle();
        chk_wr("col_ld9", 1'b1, 9, 32'hB);
        chk("col_pushpop_count", bus.fifo_count, 1);
        chk("col_sb9", bus.sb_busy, 0);
        tick();
        chk_wr("col_ld10", 1'b1, 10, 32'hC);
        chk("col_drain", bus.fifo_count, 0);
        tick();
        chk_wr("col_idle", 1'b0, 0, 0);

        // x0 suppression
        alu(0, 32'h55);
        ld(0, 32'h66);
        issue(0);
        tick();
        idle();
        chk("x0_alu_en", bus.rg_wrt_en, 0);
        chk("x0_count1", bus.fifo_count, 1);
        chk("x0_sb1", bus.sb_busy, 0);
        tick();
        chk("x0_ld_en", bus.rg_wrt_en, 0);
        chk("x0_count0", bus.fifo_count, 0);
        chk("x0_sb2", bus.sb_busy, 0);

        // Scoreboard set/clear race on register 4
        issue(4);
        tick();
        idle();
        chk("race_sb_set", bus.sb_busy, 32'h10);
        ld(4, 32'h44);
        tick();
        idle();
        issue(4);
        tick();
        idle();
        chk_wr("race_wr", 1'b1, 4, 32'h44);
        chk("race_sb_win", bus.sb_busy, 32'h10);
        ld(4, 32'h45);
        tick();
        idle();
        tick();
        chk_wr("race_wr2", 1'b1, 4, 32'h45);
        chk("race_sb_clr", bus.sb_busy, 0);

        // Reset mid-operation
        issue(7);
        tick();
        issue(8);
        tick();
        idle();
        alu(1, 32'h11);
        ld(7, 32'h77);
        tick();
        alu(1, 32'h12);
        ld(8, 32'h88);
        tick();
        idle();
        chk("mid_count", bus.fifo_count, 2);
        chk("mid_sb", bus.sb_busy, 32'h180);
        chk_wr("mid_alu", 1'b1, 1, 32'h12);
        rst = 1'b1;
        tick();
        chk("mid_rst_count", bus.fifo_count, 0);
        chk("mid_rst_sb", bus.sb_busy, 0);
        chk_wr("mid_rst_wr", 1'b0, 0, 0);
        chk("mid_rst_ready", bus.ld_wb_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_en", bus.rg_wrt_en, 0);
            chk("post_rst_count", bus.fifo_count, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
